// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Operand/result bundle for the bit-serial adder.
//   master : drives start, a, b; observes busy, done, sum, cout, ovf
//   slave  : the adder itself (opposite directions)
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. On an accepted start the operands are
//   latched and summed LSB-first through one full-adder cell and a carry
//   flop, one bit per clock. {cout, sum} and the signed overflow flag are
//   published together with a one-cycle done pulse.
// Ports
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if.slave (start, a, b in; busy, done, sum, cout, ovf out)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 partial bits need storing: the last bit goes straight
  // from the full adder into the result register.
  logic [WIDTH-2:0] psum;
  logic [WIDTH-1:0] psum_n;
  logic             carry;
  logic             c_next;
  logic             s_bit;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Full-adder cell and control decode.
  always_comb begin
    s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    psum_n = {s_bit, psum};
    last   = (cnt == CW'(WIDTH - 1));
    accept = bus.start && (state == IDLE || state == DONE);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the shift registers carry no reset; they are fully loaded on
  // every accept and nothing observes them before that.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      psum <= '0;
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      psum <= psum_n[WIDTH-1:1];
    end
  end

  // Carry, bit counter and the published result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      carry <= c_next;
      cnt   <= cnt + 1'b1;
      if (last) begin
        // On the MSB, carry holds the carry into the MSB and c_next is
        // the carry out of it; their disagreement is signed overflow.
        sum_q  <= psum_n;
        cout_q <= c_next;
        ovf_q  <= carry ^ c_next;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH = 8): reset values, a
//   directed vector table, start-while-busy, mid-operation reset, reset
//   precedence and randomized additions against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand signs.
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] s, output logic c, output logic o);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    s = full[W-1:0];
    c = full[W];
    o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge. Pulses start for one
  // accept edge, scrambles a/b afterwards, and counts edges until done.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic c, output logic o,
                        output int lat);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    lat = 0;
    while (!bus.done && lat < 4 * W) begin
      tick();
      lat++;
    end
    s = bus.sum;
    c = bus.cout;
    o = bus.ovf;
  endtask

  initial begin
    vec_t         tbl[4];
    logic [W-1:0] s, es;
    logic         c, o, ec, eo;
    int           lat;
    int           n;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    tbl[0] = '{a: 8'h5A, b: 8'h3C, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    tbl[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    tbl[3] = '{a: 8'h7F, b: 8'h00, sum: 8'h7F, cout: 1'b0, ovf: 1'b0};

    // Reset values.
    tick();
    tick();
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset sum",  32'(bus.sum),  0);
    check("reset cout", 32'(bus.cout), 0);
    check("reset ovf",  32'(bus.ovf),  0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done || bus.busy) n++;
    end
    check("no activity without start", 32'(n), 0);

    // Directed vector table.
    foreach (tbl[i]) begin
      do_add(tbl[i].a, tbl[i].b, s, c, o, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
      check($sformatf("vec%0d sum", i),  32'(s), 32'(tbl[i].sum));
      check($sformatf("vec%0d cout", i), 32'(c), 32'(tbl[i].cout));
      check($sformatf("vec%0d ovf", i),  32'(o), 32'(tbl[i].ovf));
      tick();
      check($sformatf("vec%0d done pulse width", i), 32'(bus.done), 0);
      check($sformatf("vec%0d result hold", i), 32'(bus.sum), 32'(tbl[i].sum));
    end

    // Start held through RUN with new operands; relaunch from DONE.
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.start = 1'b1;
    tick();
    bus.a = 8'h11;
    bus.b = 8'h22;
    lat = 0;
    while (!bus.done && lat < 4 * W) begin
      tick();
      lat++;
    end
    check("busy-start first latency", 32'(lat), 32'(W));
    check("busy-start first sum", 32'(bus.sum), 32'h30);
    tick();
    check("relaunch done low", 32'(bus.done), 0);
    check("relaunch busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 4 * W) begin
      tick();
      lat++;
    end
    check("relaunch spacing", 32'(lat), 32'(W + 1));
    check("relaunch sum", 32'(bus.sum), 32'h33);
    tick();

    // Reset in the middle of an operation.
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midreset busy", 32'(bus.busy), 0);
    check("midreset done", 32'(bus.done), 0);
    check("midreset sum",  32'(bus.sum),  0);
    check("midreset cout", 32'(bus.cout), 0);
    check("midreset ovf",  32'(bus.ovf),  0);
    rst_n = 1'b1;
    tick();
    tick();
    check("midreset stays idle", 32'({bus.busy, bus.done}), 0);
    do_add(8'h01, 8'h02, s, c, o, lat);
    check("post-reset latency", 32'(lat), 32'(W));
    check("post-reset sum",  32'(s), 32'h03);
    check("post-reset cout", 32'(c), 0);
    check("post-reset ovf",  32'(o), 0);
    tick();

    // Reset wins over start on the same edge.
    bus.start = 1'b1;
    rst_n     = 1'b0;
    tick();
    check("reset precedence busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();

    // Randomized additions, random idle gaps, sometimes relaunching from DONE.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      int gap;
      ra  = W'($urandom);
      rb  = W'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      ref_add(ra, rb, es, ec, eo);
      do_add(ra, rb, s, c, o, lat);
      check("rand latency", 32'(lat), 32'(W));
      if (s !== es || c !== ec || o !== eo)
        $display("  operands a=0x%0h b=0x%0h", ra, rb);
      check("rand sum",  32'(s), 32'(es));
      check("rand cout", 32'(c), 32'(ec));
      check("rand ovf",  32'(o), 32'(eo));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
